ballot_session_ctrl: RTL and testbench
======================================

# ballot_session_ctrl

Per-voter ballot sequencer in front of the vote-counting and display datapath. An officer arms one ballot. The controller waits for exactly one debounced candidate button and issues a single one-cycle `vote_valid` strobe with a one-hot candidate select, which downstream logic uses to increment counters and start the LED acknowledge. It then enforces a lockout until buttons are released. Multi-button presses, timeouts and result-mode entry are rejected, so at most one vote is cast per arming.

## Interface
- `DEBOUNCE`, 4: consecutive sampling edges a single button must be seen before casting (≥2).
- `LOCKOUT`, 10: minimum cycles spent in LOCKOUT after a cast (≥1).
- `TIMEOUT`, 1000: cycles an armed ballot may stay open (2..65535).
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `mode` in 1: 0 = voting, 1 = result display.
- `arm` in 1: officer arm level; acts on rising edge only.
- `btn` in 4: raw candidate buttons, bit i = candidate i+1.
- `vote_valid` out 1: one-cycle cast strobe.
- `vote_sel` out 4: one-hot candidate; valid only while `vote_valid`=1, otherwise 0.
- `armed` out 1: high in ARMED or DEBOUNCE.
- `busy` out 1: high in any state other than IDLE.
- `reject` out 1: one-cycle pulse on a multi-button press while armed.
- `timeout` out 1: one-cycle pulse when an armed ballot expires.
- `ballot_count` out 16: total casts, saturating at 16'hFFFF.

## Operation
States: IDLE, ARMED, DEBOUNCE, CAST, LOCKOUT.

- **IDLE**
  - `arm`=1 and `arm_d`=0 and `mode`=0 → ARMED; timer cleared.
  - `arm_d` is a registered copy of `arm` and resets to 0. `arm` held high through reset therefore arms on the first cycle after reset.
  - An arm edge with `mode`=1 is ignored.
- **ARMED** (priority top to bottom)
  - `mode`=1 → IDLE, no pulses.
  - timer == TIMEOUT-1 → IDLE, `timeout` pulse.
  - `btn` has ≥2 bits set → `reject` pulse, stay ARMED, timer keeps running.
  - `btn` has exactly one bit set → latch it into `sel`, go to DEBOUNCE, dcount=1.
  - `btn`=0 → stay.
  - Timer increments every cycle in ARMED and DEBOUNCE.
- **DEBOUNCE** (priority top to bottom)
  - `mode`=1 → IDLE.
  - timer == TIMEOUT-1 → IDLE, `timeout` pulse.
  - `btn` ≠ `sel` → ARMED, no `reject`, timer not cleared.
  - `btn` == `sel` and dcount == DEBOUNCE-1 → CAST.
  - otherwise dcount+1.
- **CAST** (exactly one cycle)
  - `vote_valid`=1, `vote_sel`=`sel`.
  - `ballot_count`+1, saturating.
  - → LOCKOUT with lcount=0. `mode` is ignored.
- **LOCKOUT**
  - lcount increments, saturating at LOCKOUT-1.
  - Leave for IDLE when lcount ≥ LOCKOUT-1 and `btn`=0. Held buttons extend LOCKOUT indefinitely.
  - `arm` edges are ignored; `arm_d` still tracks `arm`.
- **reset** at any time: IDLE, all counters 0, `ballot_count`=0. An in-flight cast is dropped with no strobe.

## Timing
- Reset values: all outputs 0, state IDLE.
- All outputs are registered.
- Arm latency: arm edge sampled at edge t → `armed`=1 and `busy`=1 after edge t.
- Cast latency: one-hot `btn` first sampled in ARMED at edge k, held stable → `vote_valid` high for the cycle after edge k+DEBOUNCE. The button must be sampled on DEBOUNCE consecutive edges.
- Timeout: armed at edge t (enters ARMED) → `timeout` pulses after edge t+TIMEOUT, and `busy` falls after the same edge.
- `reject` and `timeout` never assert in the same cycle as `vote_valid`.
- `vote_valid` is never asserted twice without an intervening return to IDLE and a fresh `arm` edge.
- `ballot_count` updates in the same cycle `vote_valid` is high.

## Test plan
- **Single cast:** reset, then an arm pulse, then `btn`=4'b0100 held 4 cycles → one `vote_valid`, `vote_sel`=4'b0100, `ballot_count`=1. `busy` stays high ≥10 cycles, drops 1 cycle after `btn`=0.
- **Glitch rejection:** armed, `btn`=4'b0001 for 2 cycles, then 0, then 4'b0010 for 4 cycles → exactly one `vote_valid` with `vote_sel`=4'b0010.
- **Multi-press:** armed, `btn`=4'b0011 for 3 cycles → `reject` pulses once per cycle, no `vote_valid`, `armed` stays 1. A following 4'b1000 held 4 cycles casts candidate 4.
- **Timeout:** TIMEOUT=20, arm with no buttons → `timeout` pulse 20 cycles after `armed` rises, `busy`=0, `ballot_count` unchanged.
- **Mode abort and reset:**
  - `mode`=1 during DEBOUNCE → IDLE with no strobe.
  - `reset` asserted in LOCKOUT → all outputs 0 next cycle, `ballot_count`=0.
- **Saturation / no double vote:**
  - Force `ballot_count`=16'hFFFF via 65535 casts (or a fast bench with a smaller count) → stays 16'hFFFF after a further cast.
  - Holding a button across LOCKOUT without a new `arm` edge → no second `vote_valid`.

Source files
------------

// File: rtl/ballot_session_ctrl.sv
// Per-voter ballot sequencer: arms one ballot, debounces a single candidate
// button, emits one cast strobe, then locks out until all buttons are released.
module ballot_session_ctrl #(
   parameter int          DEBOUNCE  = 4,
   parameter int          LOCKOUT   = 10,
   parameter int          TIMEOUT   = 1000,
   parameter logic [15:0] COUNT_MAX = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mode_i,
   input  logic        arm_i,
   input  logic [3:0]  btn_i,
   output logic        vote_valid_o,
   output logic [3:0]  vote_sel_o,
   output logic        armed_o,
   output logic        busy_o,
   output logic        reject_o,
   output logic        timeout_o,
   output logic [15:0] ballot_count_o
);

   localparam int DW = $clog2(DEBOUNCE) + 1;
   localparam int LW = $clog2(LOCKOUT) + 1;
   localparam logic [DW-1:0] DB_ONE  = DW'(1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
   localparam logic [LW-1:0] LK_ZERO = LW'(0);
   localparam logic [LW-1:0] LK_ONE  = LW'(1);
   localparam logic [LW-1:0] LK_LAST = LW'(LOCKOUT - 1);
   localparam logic [15:0]   TO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARMED    = 3'd1,
      ST_DEBOUNCE = 3'd2,
      ST_CAST     = 3'd3,
      ST_LOCKOUT  = 3'd4
   } state_e;

   function automatic logic is_multi_hot(input logic [3:0] b);
      return (b & (b - 4'd1)) != 4'd0;
   endfunction

   function automatic logic is_one_hot(input logic [3:0] b);
      return (b != 4'd0) && !is_multi_hot(b);
   endfunction

   state_e          state_q, state_d;
   logic [15:0]     timer_q, timer_d;
   logic [DW-1:0]   dcount_q, dcount_d;
   logic [LW-1:0]   lcount_q, lcount_d;
   logic [3:0]      sel_q, sel_d;
   logic            arm_q;
   logic            arm_edge;
   logic            reject_evt;
   logic            timeout_evt;

   logic            vote_valid_d;
   logic [3:0]      vote_sel_d;
   logic            armed_d;
   logic            busy_d;
   logic            reject_d;
   logic            timeout_d;
   logic [15:0]     ballot_count_d;

   logic            vote_valid_q;
   logic [3:0]      vote_sel_q;
   logic            armed_q;
   logic            busy_q;
   logic            reject_q;
   logic            timeout_q;
   logic [15:0]     ballot_count_q;

   assign arm_edge = arm_i & ~arm_q;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         timer_q  <= 16'd0;
         dcount_q <= '0;
         lcount_q <= '0;
         sel_q    <= 4'd0;
         arm_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         dcount_q <= dcount_d;
         lcount_q <= lcount_d;
         sel_q    <= sel_d;
         arm_q    <= arm_i;
      end
   end

   // Next-state and counter logic
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      dcount_d    = dcount_q;
      lcount_d    = lcount_q;
      sel_d       = sel_q;
      reject_evt  = 1'b0;
      timeout_evt = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arm_edge && !mode_i) begin
               state_d = ST_ARMED;
               timer_d = 16'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARMED: begin
            if (mode_i) begin
               state_d = ST_IDLE;
            end else if (timer_q == TO_LAST) begin
               state_d     = ST_IDLE;
               timeout_evt = 1'b1;
            end else begin
               timer_d = timer_q + 16'd1;
               if (is_multi_hot(btn_i)) begin
                  reject_evt = 1'b1;
               end else if (is_one_hot(btn_i)) begin
                  sel_d    = btn_i;
                  dcount_d = DB_ONE;
                  state_d  = ST_DEBOUNCE;
               end else begin
                  state_d = ST_ARMED;
               end
            end
         end
         ST_DEBOUNCE: begin
            if (mode_i) begin
               state_d = ST_IDLE;
            end else if (timer_q == TO_LAST) begin
               state_d     = ST_IDLE;
               timeout_evt = 1'b1;
            end else begin
               timer_d = timer_q + 16'd1;
               // A changed or extra button restarts the search without a reject.
               if (btn_i != sel_q) begin
                  state_d = ST_ARMED;
               end else if (dcount_q == DB_LAST) begin
                  state_d = ST_CAST;
               end else begin
                  dcount_d = dcount_q + DB_ONE;
               end
            end
         end
         ST_CAST: begin
            state_d  = ST_LOCKOUT;
            lcount_d = LK_ZERO;
         end
         ST_LOCKOUT: begin
            if (lcount_q < LK_LAST) begin
               lcount_d = lcount_q + LK_ONE;
            end else begin
               lcount_d = lcount_q;
            end
            if ((lcount_q >= LK_LAST) && (btn_i == 4'd0)) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_LOCKOUT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output next values; visibility follows the state being entered
   always_comb begin
      vote_valid_d   = (state_q == ST_CAST);
      vote_sel_d     = 4'd0;
      ballot_count_d = ballot_count_q;
      armed_d        = (state_d == ST_ARMED) || (state_d == ST_DEBOUNCE);
      busy_d         = (state_d != ST_IDLE);
      reject_d       = reject_evt;
      timeout_d      = timeout_evt;
      if (state_q == ST_CAST) begin
         vote_sel_d = sel_q;
         if (ballot_count_q != COUNT_MAX) begin
            ballot_count_d = ballot_count_q + 16'd1;
         end else begin
            ballot_count_d = ballot_count_q;
         end
      end else begin
         vote_sel_d = 4'd0;
      end
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         vote_valid_q   <= 1'b0;
         vote_sel_q     <= 4'd0;
         armed_q        <= 1'b0;
         busy_q         <= 1'b0;
         reject_q       <= 1'b0;
         timeout_q      <= 1'b0;
         ballot_count_q <= 16'd0;
      end else begin
         vote_valid_q   <= vote_valid_d;
         vote_sel_q     <= vote_sel_d;
         armed_q        <= armed_d;
         busy_q         <= busy_d;
         reject_q       <= reject_d;
         timeout_q      <= timeout_d;
         ballot_count_q <= ballot_count_d;
      end
   end

   assign vote_valid_o   = vote_valid_q;
   assign vote_sel_o     = vote_sel_q;
   assign armed_o        = armed_q;
   assign busy_o         = busy_q;
   assign reject_o       = reject_q;
   assign timeout_o      = timeout_q;
   assign ballot_count_o = ballot_count_q;

endmodule

// File: tb/tb_ballot_session_ctrl.sv
// Bench for ballot_session_ctrl: directed scenarios plus random stimulus,
// every cycle compared against a ballot-level reference model.
module tb_ballot_session_ctrl;

   localparam int          DEB  = 4;
   localparam int          LCK  = 10;
   localparam int          TMO  = 20;
   localparam logic [15:0] CMAX = 16'd6;

   logic        clk = 1'b0;
   logic        reset;
   logic        mode;
   logic        arm;
   logic [3:0]  btn;
   logic        vote_valid;
   logic [3:0]  vote_sel;
   logic        armed;
   logic        busy;
   logic        reject;
   logic        timeout;
   logic [15:0] ballot_count;

   ballot_session_ctrl #(
      .DEBOUNCE (DEB),
      .LOCKOUT  (LCK),
      .TIMEOUT  (TMO),
      .COUNT_MAX(CMAX)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .mode_i        (mode),
      .arm_i         (arm),
      .btn_i         (btn),
      .vote_valid_o  (vote_valid),
      .vote_sel_o    (vote_sel),
      .armed_o       (armed),
      .busy_o        (busy),
      .reject_o      (reject),
      .timeout_o     (timeout),
      .ballot_count_o(ballot_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a ballot is "open" for some age, a candidate has been
   // seen for a run of edges, a cast is due, or a cooldown is running.
   bit         m_open, m_cast_due, m_lock, m_prev_arm;
   int         m_age, m_run, m_lock_age, m_count;
   logic [3:0] m_cand;
   logic       e_vv, e_rej, e_to;
   logic [3:0] e_sel;

   int         vv_seen, rej_seen;
   logic [3:0] last_sel;

   task automatic model_edge();
      e_vv = 1'b0; e_sel = 4'd0; e_rej = 1'b0; e_to = 1'b0;
      if (reset) begin
         m_open = 0; m_cast_due = 0; m_lock = 0; m_prev_arm = 0;
         m_age = 0; m_run = 0; m_lock_age = 0; m_count = 0; m_cand = 4'd0;
      end else begin
         if (m_cast_due) begin
            e_vv = 1'b1;
            e_sel = m_cand;
            if (m_count < int'(CMAX)) m_count++;
            m_cast_due = 0;
            m_lock = 1;
            m_lock_age = 0;
         end else if (m_lock) begin
            if (m_lock_age >= LCK - 1 && btn == 4'd0) m_lock = 0;
            else if (m_lock_age < LCK - 1) m_lock_age++;
         end else if (m_open) begin
            if (mode) begin
               m_open = 0;
            end else if (m_age == TMO - 1) begin
               m_open = 0;
               e_to = 1'b1;
            end else begin
               m_age++;
               if (m_run > 0) begin
                  if (btn == m_cand) begin
                     if (m_run == DEB - 1) begin
                        m_open = 0;
                        m_cast_due = 1;
                     end else begin
                        m_run++;
                     end
                  end else begin
                     m_run = 0;
                  end
               end else if ($countones(btn) >= 2) begin
                  e_rej = 1'b1;
               end else if ($countones(btn) == 1) begin
                  m_cand = btn;
                  m_run = 1;
               end
            end
         end else if (arm && !m_prev_arm && !mode) begin
            m_open = 1;
            m_age = 0;
            m_run = 0;
         end
         m_prev_arm = arm;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("vote_valid", 32'(vote_valid), 32'(e_vv));
      check("vote_sel", 32'(vote_sel), 32'(e_sel));
      check("armed", 32'(armed), 32'(m_open));
      check("busy", 32'(busy), 32'(m_open | m_cast_due | m_lock));
      check("reject", 32'(reject), 32'(e_rej));
      check("timeout", 32'(timeout), 32'(e_to));
      check("ballot_count", 32'(ballot_count), 32'(m_count));
      if (vote_valid) begin
         vv_seen++;
         last_sel = vote_sel;
      end
      if (reject) rej_seen++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic arm_pulse();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   logic [15:0] cnt_before;

   initial begin
      reset = 1'b1; arm = 1'b0; mode = 1'b0; btn = 4'd0;
      vv_seen = 0; rej_seen = 0; last_sel = 4'd0;
      run(3);
      reset = 1'b0;
      step();

      // single cast with long hold
      vv_seen = 0;
      arm_pulse();
      btn = 4'b0100;
      run(18);
      check("single_busy_held", 32'(busy), 32'd1);
      btn = 4'd0;
      step();
      check("single_busy_drop", 32'(busy), 32'd0);
      check("single_casts", 32'(vv_seen), 32'd1);
      check("single_sel", 32'(last_sel), 32'b0100);
      check("single_count", 32'(ballot_count), 32'd1);

      // glitch rejection
      vv_seen = 0;
      arm_pulse();
      btn = 4'b0001; run(2);
      btn = 4'd0;    run(1);
      btn = 4'b0010; run(6);
      btn = 4'd0;    run(15);
      check("glitch_casts", 32'(vv_seen), 32'd1);
      check("glitch_sel", 32'(last_sel), 32'b0010);

      // multi-press
      vv_seen = 0; rej_seen = 0;
      arm_pulse();
      btn = 4'b0011; run(3);
      check("multi_rejects", 32'(rej_seen), 32'd3);
      check("multi_armed", 32'(armed), 32'd1);
      check("multi_no_cast", 32'(vv_seen), 32'd0);
      btn = 4'b1000; run(6);
      btn = 4'd0;    run(15);
      check("multi_casts", 32'(vv_seen), 32'd1);
      check("multi_sel", 32'(last_sel), 32'b1000);

      // timeout
      cnt_before = ballot_count;
      arm_pulse();
      run(TMO);
      check("timeout_pulse", 32'(timeout), 32'd1);
      check("timeout_busy", 32'(busy), 32'd0);
      check("timeout_count", 32'(ballot_count), 32'(cnt_before));
      step();
      check("timeout_one_cycle", 32'(timeout), 32'd0);

      // mode abort during debounce
      vv_seen = 0;
      arm_pulse();
      btn = 4'b0001; run(2);
      mode = 1'b1; step();
      check("abort_armed", 32'(armed), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      mode = 1'b0; run(6);
      btn = 4'd0;  run(2);
      check("abort_no_cast", 32'(vv_seen), 32'd0);

      // reset during lockout
      arm_pulse();
      btn = 4'b0100; run(7);
      reset = 1'b1; step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(ballot_count), 32'd0);
      reset = 1'b0; btn = 4'd0; step();

      // arm held through reset arms on the first cycle out of reset
      reset = 1'b1; arm = 1'b1; run(2);
      reset = 1'b0; step();
      check("arm_through_reset", 32'(armed), 32'd1);
      arm = 1'b0; mode = 1'b1; step();
      mode = 1'b0; step();

      // saturation
      vv_seen = 0;
      for (int i = 0; i < int'(CMAX) + 2; i++) begin
         arm_pulse();
         btn = 4'b0001; run(6);
         btn = 4'd0;    run(12);
      end
      check("sat_casts", 32'(vv_seen), 32'(CMAX) + 32'd2);
      check("sat_count", 32'(ballot_count), 32'(CMAX));

      // held button across lockout, no fresh arm edge
      vv_seen = 0;
      arm_pulse();
      btn = 4'b0010; run(40);
      check("no_double_vote", 32'(vv_seen), 32'd1);
      btn = 4'd0; run(2);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 19))
               0, 1, 2, 3, 4, 5, 6, 7, 8, 9: btn = 4'd0;
               10, 11, 12, 13, 14, 15, 16: btn = 4'b0001 << $urandom_range(0, 3);
               default: btn = 4'($urandom_range(0, 15));
            endcase
         end
         if ($urandom_range(0, 7) == 0) arm = ~arm;
         mode  = ($urandom_range(0, 39) == 0);
         reset = ($urandom_range(0, 499) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
